btn_mode_ctl: RTL and testbench
===============================

// Module: btn_mode_ctl
// PURPOSE
//  N-channel push-button front end and mode controller for the watch/stopwatch top.
//  - Per channel: synchroniser, debounce, rise/fall pulses, optional toggle register.
//  - Provides a run/clear interlock: clear is accepted only while stopped.
//  - Sits between the board tact switches and the display/counter datapath.
// PARAMETERS
//  N_BTN        4          number of button channels (1..16)
//  DB_CYCLES    1000000    stable cycles before a level is accepted (10 ms @ 100 MHz)
//  TOG_MASK     4'b0011    bit i=1: channel i drives a toggle register
//  RUN_IDX      0          channel whose toggle is the run mode
//  CLR_IDX      2          channel used as the clear button
//  LONG_CYCLES  200000000  hold time for a long-press pulse (2 s @ 100 MHz)
// PORTS
//  clk         in   1      system clock, 100 MHz
//  rst         in   1      reset, synchronous, active-high
//  btn_in      in   N_BTN  raw switch inputs, asynchronous, pressed = 1
//  key_lvl     out  N_BTN  debounced level
//  key_rise    out  N_BTN  1-cycle pulse on the debounced press
//  key_fall    out  N_BTN  1-cycle pulse on the debounced release
//  tog         out  N_BTN  toggle registers; bits with TOG_MASK=0 are held at 0
//  run_md      out  1      equals tog[RUN_IDX]
//  clr_on      out  1      clear request, held high while clear is pressed and accepted
//  long_press  out  N_BTN  1-cycle long-press pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every flop is cleared on a clk edge with rst=1.
//    - Affects synchronisers, counters and all outputs.
//    - All outputs read 0 in the cycle after reset.
//  - Synchroniser: 2 flops per channel; produces sync[i].
//  - Debounce, per channel, with a count register of width $clog2(DB_CYCLES):
//    - sync==key_lvl: cnt<=0.
//    - Otherwise cnt increments.
//    - At cnt==DB_CYCLES-1 with sync still different: key_lvl<=sync, cnt<=0.
//    - Any glitch shorter than DB_CYCLES restarts the count.
//  - Latency: a raw change held steadily appears on key_lvl 2+DB_CYCLES clk edges later.
//  - key_rise[i] is high only in the first cycle key_lvl[i] reads 1.
//  - key_fall[i] is high only in the first cycle key_lvl[i] reads 0 after a 1.
//  - Rise and fall are never high together on one channel.
//  - Toggle: when key_rise[i]=1 and TOG_MASK[i]=1, tog[i] flips on the next edge.
//  - Clear interlock, priority order:
//    1. key_fall[CLR_IDX] -> clr_on<=0.
//    2. Else key_rise[CLR_IDX] and run_md==0 -> clr_on<=1.
//       - run_md is sampled before any same-cycle toggle.
//    3. Else clr_on holds its value.
//  - Clear press while running: ignored, and stays ignored until the next press.
//    - Stopping while clear is still held does not set clr_on.
//  - Pressing run while clr_on=1: run toggles; clr_on stays high until clear is released.
//  - Channels are independent; simultaneous events on different channels are all honoured.
//  - Button held through reset release: after reset key_lvl=0, so a key_rise follows
//    2+DB_CYCLES cycles later.
// CONFIGURATION
//  - Macro: BTN_LONG_PRESS_EN.
//  - Defined:
//    - Each channel has a hold counter, width $clog2(LONG_CYCLES), cleared while key_lvl=0.
//    - long_press[i] pulses for 1 cycle when key_lvl[i] has been 1 for LONG_CYCLES cycles.
//    - The counter then saturates, so there is one pulse per press.
//    - Release before the threshold gives no pulse.
//  - Undefined:
//    - The hold counters are not built; long_press is tied to 0.
//    - The port list is unchanged.
// STRUCTURE
//  - Package btn_ctl_pkg:
//    - default DB_CYCLES/LONG_CYCLES constants for 100 MHz;
//    - the simulation-scale constants DB_SIM=4 and LONG_SIM=16;
//    - channel index constants BTN_RUN=0, BTN_DISP=1, BTN_CLR=2, BTN_AUX=3.
//  - Sub-module btn_debounce: one channel.
//    - Contains the synchroniser, debounce counter, rise/fall and optional hold counter.
//    - Instantiated N_BTN times in a generate loop.
//  - The top holds the toggle registers and the clear interlock.
// TESTING (DB_CYCLES=4, LONG_CYCLES=16, defaults otherwise)
//  1. Reset: rst=1 for 3 cycles with btn_in=4'hF, then release.
//     -> all outputs 0 at release.
//     -> key_lvl=4'hF 6 cycles later, with key_rise=4'hF for exactly 1 cycle.
//  2. Glitch: btn_in[1] high for 3 cycles, then low.
//     -> key_lvl, key_rise and tog stay 0.
//     -> Held for 10 cycles instead: key_rise[1] occurs once and tog[1] flips to 1.
//  3. Clear while running:
//     - Press run: run_md=1.
//     - Press clear: clr_on stays 0.
//     - Press run: run_md=0.
//     - Press clear again: clr_on=1 until key_fall[2], then 0.
//  4. Same-cycle events, with run_md=0:
//     - Run and clear pressed in the same cycle.
//     -> clr_on=1 and run_md=1 in the same cycle.
//  5. Non-toggle channel: 3 presses on channel 3.
//     -> key_rise[3] pulses 3 times; tog[3] stays 0.
//  6. Long press:
//     - With BTN_LONG_PRESS_EN: hold btn_in[0] for 40 cycles.
//       -> exactly one long_press[0] pulse, 16 cycles after key_rise[0].
//     - Without the macro: long_press stays 0.

Source files
------------

// File: rtl/btn_mode_ctl_pkg.sv
// Shared constants for the push-button front end and mode controller.
// Long-press hold counters are built only when BTN_LONG_PRESS_EN is defined.
package btn_ctl_pkg;

  localparam int unsigned DB_CYCLES_DEF   = 1000000;    // 10 ms at 100 MHz
  localparam int unsigned LONG_CYCLES_DEF = 200000000;  // 2 s at 100 MHz

  localparam int unsigned DB_SIM   = 4;
  localparam int unsigned LONG_SIM = 16;

  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_DISP = 1;
  localparam int unsigned BTN_CLR  = 2;
  localparam int unsigned BTN_AUX  = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_mode_ctl_if.sv
// Button/mode bundle between the board switches and the controller.
// Carries long_press in every build; it reads 0 unless BTN_LONG_PRESS_EN is defined.
interface btn_mode_ctl_if #(
  parameter int unsigned N_BTN = 4
) ();

  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] key_lvl;
  logic [N_BTN-1:0] key_rise;
  logic [N_BTN-1:0] key_fall;
  logic [N_BTN-1:0] tog;
  logic             run_md;
  logic             clr_on;
  logic [N_BTN-1:0] long_press;

  modport master (
    output btn_in,
    input  key_lvl, key_rise, key_fall, tog, run_md, clr_on, long_press
  );

  modport slave (
    input  btn_in,
    output key_lvl, key_rise, key_fall, tog, run_md, clr_on, long_press
  );

endinterface

// File: rtl/btn_mode_ctl_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, rise/fall pulses and,
// with BTN_LONG_PRESS_EN defined, a saturating hold counter for the long-press pulse.
module btn_debounce
  import btn_ctl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic key_lvl,
  output logic key_rise,
  output logic key_fall,
  output logic long_press
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synchronised level only after it has differed for DB_CYCLES cycles.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        lvl_d  = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_lvl  = lvl_q;
  assign key_rise = rise_q;
  assign key_fall = fall_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES);

  logic              fired_q, fired_d;
  logic              long_q, long_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Count held cycles; fired freezes the counter so each press pulses once.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (!lvl_q) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (!fired_q) begin
      if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_mode_ctl.sv
// Push-button front end and run/clear mode controller for the watch/stopwatch top.
// Long-press detection is included when BTN_LONG_PRESS_EN is defined.
module btn_mode_ctl
  import btn_ctl_pkg::*;
#(
  parameter int unsigned      N_BTN       = 4,
  parameter int unsigned      DB_CYCLES   = DB_CYCLES_DEF,
  parameter logic [N_BTN-1:0] TOG_MASK    = N_BTN'(4'b0011),
  parameter int unsigned      RUN_IDX     = BTN_RUN,
  parameter int unsigned      CLR_IDX     = BTN_CLR,
  parameter int unsigned      LONG_CYCLES = LONG_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  btn_mode_ctl_if.slave bus
);

  logic [N_BTN-1:0] key_lvl, key_rise, key_fall, long_press;
  logic [N_BTN-1:0] tog_q, tog_d;
  logic             clr_q, clr_d;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (bus.btn_in[i]),
      .key_lvl   (key_lvl[i]),
      .key_rise  (key_rise[i]),
      .key_fall  (key_fall[i]),
      .long_press(long_press[i])
    );
  end

  // Toggles and clear interlock; run mode is sampled before its own same-cycle flip.
  always_comb begin
    tog_d = tog_q ^ (key_rise & TOG_MASK);
    clr_d = clr_q;
    if (key_fall[CLR_IDX]) begin
      clr_d = 1'b0;
    end else if (key_rise[CLR_IDX] && !tog_q[RUN_IDX]) begin
      clr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q <= '0;
      clr_q <= 1'b0;
    end else begin
      tog_q <= tog_d;
      clr_q <= clr_d;
    end
  end

  assign bus.key_lvl    = key_lvl;
  assign bus.key_rise   = key_rise;
  assign bus.key_fall   = key_fall;
  assign bus.long_press = long_press;
  assign bus.tog        = tog_q;
  assign bus.run_md     = tog_q[RUN_IDX];
  assign bus.clr_on     = clr_q;

endmodule

// File: tb/tb_btn_mode_ctl.sv
// Self-checking bench for btn_mode_ctl at simulation scale (DB=4, LONG=16).
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_mode_ctl;
  import btn_ctl_pkg::*;

  localparam int unsigned      N  = 4;
  localparam int unsigned      DB = DB_SIM;
  localparam int unsigned      LG = LONG_SIM;
  localparam logic [N-1:0]     TM = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_mode_ctl_if #(.N_BTN(N)) bif ();

  btn_mode_ctl #(
    .N_BTN      (N),
    .DB_CYCLES  (DB),
    .TOG_MASK   (TM),
    .RUN_IDX    (BTN_RUN),
    .CLR_IDX    (BTN_CLR),
    .LONG_CYCLES(LG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last DB synchronised samples all
  // disagree with it; the synchroniser is a two-deep delay line of raw samples.
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_tog = '0, m_long = '0;
  logic         m_clr = 1'b0;
  logic [N-1:0] m_win [DB];
  int           m_run [N];
  logic [N-1:0] t_flip, t_lvl, t_long;

  always begin : compare
    @(posedge clk);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
      m_tog = '0; m_long = '0; m_clr = 1'b0;
      for (int k = 0; k < int'(DB); k++) m_win[k] = '0;
      for (int i = 0; i < int'(N); i++) m_run[i] = 0;
    end else begin
      for (int k = int'(DB) - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_s2;
      t_flip = '1;
      for (int k = 0; k < int'(DB); k++) t_flip &= (m_win[k] ^ m_lvl);
      t_lvl = m_lvl ^ t_flip;
      for (int i = 0; i < int'(N); i++) begin
        if (m_lvl[i]) m_run[i] = (m_run[i] > int'(LG)) ? m_run[i] : m_run[i] + 1;
        else          m_run[i] = 0;
        t_long[i] = (m_run[i] == int'(LG));
      end
      if (m_fall[BTN_CLR])                         m_clr = 1'b0;
      else if (m_rise[BTN_CLR] && !m_tog[BTN_RUN]) m_clr = 1'b1;
      m_tog  = m_tog ^ (m_rise & TM);
      m_rise = t_flip & t_lvl;
      m_fall = t_flip & ~t_lvl;
      m_lvl  = t_lvl;
`ifdef BTN_LONG_PRESS_EN
      m_long = t_long;
`else
      m_long = '0;
`endif
      m_s2 = m_s1;
      m_s1 = bif.btn_in;
    end
    #1;
    chk("key_lvl",    32'(bif.key_lvl),    32'(m_lvl));
    chk("key_rise",   32'(bif.key_rise),   32'(m_rise));
    chk("key_fall",   32'(bif.key_fall),   32'(m_fall));
    chk("tog",        32'(bif.tog),        32'(m_tog));
    chk("run_md",     32'(bif.run_md),     32'(m_tog[BTN_RUN]));
    chk("clr_on",     32'(bif.clr_on),     32'(m_clr));
    chk("long_press", 32'(bif.long_press), 32'(m_long));
  end

  int rcnt [N];
  int lcnt, cyc_no, rise0_at, long0_at;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc_no++;
      for (int i = 0; i < int'(N); i++) if (bif.key_rise[i]) rcnt[i]++;
      if (bif.key_rise[0]) rise0_at = cyc_no;
      if (bif.long_press[0]) begin
        lcnt++;
        long0_at = cyc_no;
      end
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < int'(N); i++) rcnt[i] = 0;
    lcnt = 0; rise0_at = -1; long0_at = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.btn_in = '0;
    cyc(3);
    rst = 1'b0;
    clr_cnt();
  endtask

  task automatic press(input logic [N-1:0] m, input int hold);
    bif.btn_in = m;
    cyc(hold);
    bif.btn_in = '0;
    cyc(8);
  endtask

  int found;

  initial begin
    bif.btn_in = '0;
    cyc_no = 0;
    clr_cnt();

    // 1: reset with all buttons held
    rst = 1'b1;
    bif.btn_in = 4'hF;
    cyc(3);
    rst = 1'b0;
    chk("rst_key_lvl", 32'(bif.key_lvl), 0);
    chk("rst_tog",     32'(bif.tog), 0);
    chk("rst_clr_on",  32'(bif.clr_on), 0);
    chk("rst_run_md",  32'(bif.run_md), 0);
    cyc(6);
    chk("rst_lvl_after6",  32'(bif.key_lvl), 32'hF);
    chk("rst_rise_after6", 32'(bif.key_rise), 32'hF);
    cyc(1);
    chk("rst_rise_after7", 32'(bif.key_rise), 0);

    // 2: glitch shorter than the debounce window, then a real press
    do_reset();
    bif.btn_in = 4'b0010;
    cyc(3);
    bif.btn_in = '0;
    cyc(10);
    chk("glitch_lvl",  32'(bif.key_lvl), 0);
    chk("glitch_rise", 32'(rcnt[1]), 0);
    chk("glitch_tog",  32'(bif.tog), 0);
    press(4'b0010, 10);
    chk("held_rise_cnt", 32'(rcnt[1]), 1);
    chk("held_tog1",     32'(bif.tog[1]), 1);

    // 3: clear is refused while running
    do_reset();
    press(4'b0001, 8);
    chk("run_on", 32'(bif.run_md), 1);
    press(4'b0100, 8);
    chk("clr_ignored", 32'(bif.clr_on), 0);
    press(4'b0001, 8);
    chk("run_off", 32'(bif.run_md), 0);
    bif.btn_in = 4'b0100;
    cyc(8);
    chk("clr_accepted", 32'(bif.clr_on), 1);
    bif.btn_in = '0;
    found = 0;
    for (int w = 0; w < 20 && found == 0; w++) begin
      cyc(1);
      if (bif.key_fall[BTN_CLR]) found = 1;
    end
    chk("clr_fall_seen",  32'(found), 1);
    chk("clr_on_at_fall", 32'(bif.clr_on), 1);
    cyc(1);
    chk("clr_on_after_fall", 32'(bif.clr_on), 0);

    // 4: run and clear pressed together while stopped
    do_reset();
    bif.btn_in = 4'b0101;
    cyc(6);
    chk("same_rise", 32'(bif.key_rise), 32'h5);
    cyc(1);
    chk("same_run", 32'(bif.run_md), 1);
    chk("same_clr", 32'(bif.clr_on), 1);
    bif.btn_in = '0;
    cyc(8);

    // 5: non-toggle channel
    do_reset();
    for (int p = 0; p < 3; p++) press(4'b1000, 8);
    chk("aux_rises", 32'(rcnt[3]), 3);
    chk("aux_tog",   32'(bif.tog[3]), 0);

    // 6: long press
    do_reset();
    press(4'b0001, 40);
`ifdef BTN_LONG_PRESS_EN
    chk("long_count", 32'(lcnt), 1);
    chk("long_delay", 32'(long0_at - rise0_at), 16);
`else
    chk("long_count", 32'(lcnt), 0);
`endif

    // random traffic against the model
    for (int r = 0; r < 400; r++) begin
      rst = ($urandom_range(0, 39) == 0);
      bif.btn_in = N'($urandom);
      cyc($urandom_range(1, 9));
    end
    rst = 1'b0;
    bif.btn_in = '0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
